vec_sequencer: RTL and testbench
================================

# vec_sequencer

Stimulus sequencer that sits directly upstream of the 3-input combinational function block. It holds a small programmable table of 3-bit vectors and plays them onto the block's `a`, `b` and `c` inputs, holding each vector for a programmable number of cycles. At the end of each vector's hold window it samples the block's `z` output into a result word. It replaces bench-only vector playback with synthesizable hardware, so the function can be exercised on silicon.

## Interface
- `DEPTH`, 8: number of vector table entries; power of two.
- `AW`, 3: table address width, equal to log2(DEPTH).
- `HOLD_W`, 8: width of the hold-count input.

- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `wr_en`  in  1: table write strobe; honoured only in IDLE.
- `wr_addr`  in  AW: table write address.
- `wr_data`  in  3: vector to store, ordered {a,b,c} with a as the MSB.
- `hold`  in  HOLD_W: cycles per vector; 0 is treated as 1; latched on start.
- `start`  in  1: begin a run; honoured only in IDLE.
- `abort`  in  1: synchronous abort of a run; ignored in IDLE.
- `a`, `b`, `c`  out  1 each: registered vector bits driven to the downstream block.
- `z`  in  1: function output returned from the downstream block.
- `busy`  out  1: high while a run is in progress.
- `done`  out  1: one-cycle pulse when a run completes normally.
- `idx`  out  AW: index of the vector currently applied.
- `result`  out  DEPTH: `result[i]` holds `z` as sampled for vector i.

## Operation
- Two states, IDLE and RUN.
- Reset: state IDLE; `a`, `b`, `c`, `busy`, `done`, `idx`, `result`, the hold counter and all table entries are 0.
- IDLE:
  - `wr_en` writes `wr_data` to `mem[wr_addr]` at the edge.
  - `start` at an edge enters RUN: `{a,b,c}<=mem[0]`, `idx<=0`, `cnt<=0`, `result<=0`, `busy<=1`, `H<=max(hold,1)`.
  - If `start` and `wr_en` are high at the same edge, the write lands first; the run uses the updated `mem[0]`.
- RUN:
  - On an edge with `cnt==H-1`: `result[idx]<=z`.
  - At that edge, if `idx<DEPTH-1`: `idx<=idx+1`, `{a,b,c}<=mem[idx+1]`, `cnt<=0`.
  - If `idx==DEPTH-1`: go to IDLE with `busy<=0`, `done<=1` and `{a,b,c}<=0`; `idx` holds at DEPTH-1.
  - Otherwise `cnt<=cnt+1`.
  - `start` and `wr_en` are ignored; the table cannot change mid-run.
- `abort` in RUN (takes priority over sampling at the same edge):
  - goes to IDLE with `busy<=0` and `{a,b,c}<=0`;
  - no `done` pulse; `result` keeps the bits already sampled.
- `done` is high for exactly one cycle, then returns to 0.
- Asynchronous reset mid-run clears everything immediately, including the table.

## Timing
- Vector i is applied to `a`, `b`, `c` for exactly H cycles.
- `z` is sampled at the edge that ends the vector's window, so the combinational path has H cycles minus setup to settle.
- A full run lasts DEPTH×H cycles with `busy` high.
- `done` rises at the same edge `busy` falls.
- Back-to-back runs: `start` may be asserted in the cycle `done` is high; the new run begins at the following edge.

## Structure
- A shared package holds:
  - the state enum (IDLE, RUN);
  - default constants DEPTH=8, AW=3, HOLD_W=8;
  - the {a,b,c} bit-ordering convention.
- Natural sub-module: `vec_table` (DEPTH×3 register file with async clear, one write port and one combinational read port).
- The sequencer FSM, hold counter and result capture stay in `vec_sequencer`.
- The combinational function block is instantiated beside the sequencer at the next level up, not inside it.

## Test plan
Bench drives the real function z=(a&b)|~(b&~c); expected z is 0 only for abc=010.
- Reset: assert `rst_n`=0 mid-cycle -> immediately `a`/`b`/`c`/`busy`/`done`/`result`=0; the table reads back all zero on a subsequent run.
- Basic run: load `mem[i]=i` for i=0..7, `hold`=1, `start` -> `abc` steps 000..111 one per cycle; `busy` high 8 cycles; `result`=8'hFB; `done` pulses once.
- Long hold: `hold`=4 -> each vector held 4 cycles; `busy` high 32 cycles; `result`=8'hFB.
- Zero hold: `hold`=0 -> identical to the `hold`=1 run (8 cycles, `result`=8'hFB).
- Abort and ignored inputs:
  - during a run, pulse `start` and write `mem[0]`=111 -> both ignored; next run still starts with 000;
  - `abort` in cycle 3 -> `busy`=0, no `done`, `result`=8'b0000_0011.
- Reset mid-run at cycle 5 with `hold`=2 -> all outputs 0 immediately; a fresh run after reloading the table completes normally.

Source files
------------

// File: rtl/vec_sequencer_pkg.sv
// Shared definitions for the vector sequencer: default sizes, FSM states and
// the {a,b,c} bit ordering used for every stored and applied vector.
package vec_sequencer_pkg;

    localparam int DEPTH_DEF  = 8;
    localparam int AW_DEF     = 3;
    localparam int HOLD_W_DEF = 8;

    // Vector layout: a is the MSB, c the LSB
    localparam int VEC_W = 3;
    localparam int A_BIT = 2;
    localparam int B_BIT = 1;
    localparam int C_BIT = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/vec_sequencer_table.sv
// DEPTH x 3-bit vector register file: async clear, one write port and one
// combinational read port.
module vec_table
    import vec_sequencer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [VEC_W-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [VEC_W-1:0] o_rd_data
);

    logic [DEPTH-1:0][VEC_W-1:0] w_rows;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [VEC_W-1:0] r_entry;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_entry <= '0;
                end else if (i_wr_en && (i_wr_addr == AW'(gi))) begin
                    r_entry <= i_wr_data;
                end
            end

            assign w_rows[gi] = r_entry;
        end
    endgenerate

    assign o_rd_data = w_rows[i_rd_addr];

endmodule

// File: rtl/vec_sequencer.sv
// Plays a programmable table of {a,b,c} vectors onto a downstream block,
// holding each for H cycles and capturing z at the end of each window.
module vec_sequencer
    import vec_sequencer_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int AW     = AW_DEF,
    parameter int HOLD_W = HOLD_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [VEC_W-1:0]  wr_data,
    input  logic [HOLD_W-1:0] hold,
    input  logic              start,
    input  logic              abort,
    output logic              a,
    output logic              b,
    output logic              c,
    input  logic              z,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     idx,
    output logic [DEPTH-1:0]  result
);

    state_e            r_state;
    logic [VEC_W-1:0]  r_vec;
    logic [AW-1:0]     r_idx;
    logic [HOLD_W-1:0] r_cnt;
    logic [HOLD_W-1:0] r_hold;
    logic [DEPTH-1:0]  r_result;
    logic              r_busy;
    logic              r_done;

    logic              w_idle;
    logic              w_tbl_wr_en;
    logic [AW-1:0]     w_rd_addr;
    logic [VEC_W-1:0]  w_rd_data;
    logic [VEC_W-1:0]  w_first_vec;
    logic [HOLD_W-1:0] w_hold_eff;
    logic              w_window_end;
    logic              w_last_vec;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_tbl_wr_en = wr_en && w_idle;

    // In IDLE the read port looks at entry 0 for the run start; in RUN it
    // prefetches the next entry so the step needs no extra cycle.
    assign w_rd_addr = w_idle ? '0 : (r_idx + AW'(1));

    // A write to entry 0 on the start edge must be seen by the new run
    assign w_first_vec = (w_tbl_wr_en && (wr_addr == '0)) ? wr_data : w_rd_data;

    assign w_hold_eff   = (hold == '0) ? HOLD_W'(1) : hold;
    assign w_window_end = (r_cnt == (r_hold - HOLD_W'(1)));
    assign w_last_vec   = (r_idx == AW'(DEPTH - 1));

    vec_table #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_tbl_wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_vec    <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_hold   <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state  <= ST_RUN;
                        r_vec    <= w_first_vec;
                        r_idx    <= '0;
                        r_cnt    <= '0;
                        r_result <= '0;
                        r_busy   <= 1'b1;
                        r_hold   <= w_hold_eff;
                    end
                end
                ST_RUN: begin
                    // Abort wins over a sample due at the same edge
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_vec   <= '0;
                    end else if (w_window_end) begin
                        r_result[r_idx] <= z;
                        if (!w_last_vec) begin
                            r_idx <= r_idx + AW'(1);
                            r_vec <= w_rd_data;
                            r_cnt <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_vec   <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + HOLD_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign a      = r_vec[A_BIT];
    assign b      = r_vec[B_BIT];
    assign c      = r_vec[C_BIT];
    assign busy   = r_busy;
    assign done   = r_done;
    assign idx    = r_idx;
    assign result = r_result;

endmodule

// File: tb/tb_vec_sequencer.sv
// Directed bench for vec_sequencer driving z=(a&b)|~(b&~c) back into the DUT.
module tb_vec_sequencer;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [2:0] wr_data;
    logic [7:0] hold;
    logic       start;
    logic       abort;
    logic       a, b, c;
    logic       z;
    logic       busy;
    logic       done;
    logic [2:0] idx;
    logic [7:0] result;

    int total = 0;
    int bad   = 0;

    logic [2:0] exp_mem [8];

    typedef struct {
        logic [7:0] hold_v;
        int         cycles;
        logic [7:0] res;
    } run_vec_t;

    run_vec_t runs [3];

    vec_sequencer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .hold    (hold),
        .start   (start),
        .abort   (abort),
        .a       (a),
        .b       (b),
        .c       (c),
        .z       (z),
        .busy    (busy),
        .done    (done),
        .idx     (idx),
        .result  (result)
    );

    // Downstream function block: z is 0 only for abc=010
    assign z = (a & b) | ~(b & ~c);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] addr, input logic [2:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick();
        wr_en = 1'b0;
        exp_mem[addr] = data;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 8; i++) load(3'(i), 3'(i));
    endtask

    // Runs one full sequence and checks every applied vector, the run length,
    // the completion outputs and the done pulse width.
    task automatic do_run(input logic [7:0] h, input int exp_cycles,
                          input logic [7:0] exp_res, input bit b2b);
        int heff;
        int cyc;
        int ie;
        heff  = (h == 8'd0) ? 1 : int'(h);
        hold  = h;
        start = 1'b1;
        tick();
        start = 1'b0;
        hold  = 8'd7;
        cyc   = 0;
        while (busy && cyc < 600) begin
            ie = cyc / heff;
            if (ie > 7) ie = 7;
            check("abc", 32'({a, b, c}), 32'(exp_mem[ie]));
            check("idx", 32'(idx), 32'(ie));
            tick();
            cyc++;
        end
        check("busy_cycles", 32'(cyc), 32'(exp_cycles));
        check("done_pulse", 32'(done), 32'd1);
        check("result", 32'(result), 32'(exp_res));
        check("abc_end", 32'({a, b, c}), 32'd0);
        check("idx_end", 32'(idx), 32'd7);
        $display("run hold=%0d cycles=%0d result=%02h done=%0b", h, cyc, result, done);
        if (b2b) begin
            hold  = h;
            start = 1'b1;
        end
        tick();
        start = 1'b0;
        check("done_clear", 32'(done), 32'd0);
        check("busy_after", 32'(busy), 32'(b2b));
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        hold    = '0;
        start   = 1'b0;
        abort   = 1'b0;
        for (int i = 0; i < 8; i++) exp_mem[i] = 3'd0;

        runs[0] = '{hold_v: 8'd1, cycles: 8,  res: 8'hFB};
        runs[1] = '{hold_v: 8'd4, cycles: 32, res: 8'hFB};
        runs[2] = '{hold_v: 8'd0, cycles: 8,  res: 8'hFB};

        #3;
        check("rst_abc", 32'({a, b, c}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_idx", 32'(idx), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        $display("reset outputs abc=%0b%0b%0b busy=%0b result=%02h", a, b, c, busy, result);
        #10 rst_n = 1'b1;
        tick();

        load_ramp();
        for (int r = 0; r < 3; r++)
            do_run(runs[r].hold_v, runs[r].cycles, runs[r].res, 1'b0);

        // Back-to-back start in the done cycle, then ignored inputs and abort
        do_run(8'd1, 8, 8'hFB, 1'b1);
        hold = 8'd1;
        check("b2b_abc0", 32'({a, b, c}), 32'd0);
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 3'd0;
        wr_data = 3'b111;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        check("ign_abc1", 32'({a, b, c}), 32'd1);
        check("ign_busy", 32'(busy), 32'd1);
        tick();
        check("ign_abc2", 32'({a, b, c}), 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'h03);
        check("abort_abc", 32'({a, b, c}), 32'd0);
        $display("abort busy=%0b done=%0b result=%02h", busy, done, result);
        tick();
        check("abort_done_late", 32'(done), 32'd0);
        check("abort_result_hold", 32'(result), 32'h03);
        do_run(8'd1, 8, 8'hFB, 1'b0);

        // Asynchronous reset mid-run, mid-cycle
        hold  = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("mid_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_abc", 32'({a, b, c}), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_idx", 32'(idx), 32'd0);
        check("mrst_result", 32'(result), 32'd0);
        $display("mid-run reset busy=%0b result=%02h", busy, result);
        #2 rst_n = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) exp_mem[i] = 3'd0;
        do_run(8'd1, 8, 8'hFF, 1'b0);
        load_ramp();
        do_run(8'd2, 16, 8'hFB, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
